// File: rtl/cache_defs_pkg.sv
// Shared icache definitions: refill responder state encoding and default line/word geometry.
package cache_defs;

   localparam int ICACHE_LINE_WIDTH = 128;
   localparam int ICACHE_WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      RESP_IDLE,
      RESP_ISSUE,
      RESP_WAIT,
      RESP_ACK,
      RESP_DRAIN
   } type_icache_resp_states_e;

endpackage

// File: rtl/icache_refill_buffer.sv
// Line assembly register for icache refills: one word slot per beat, written by beat index.
module icache_refill_buffer
   import cache_defs::*;
#(
   parameter int WORD_WIDTH = ICACHE_WORD_WIDTH,
   parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
   localparam int BEATS = LINE_WIDTH / WORD_WIDTH,
   localparam int CNT_W = $clog2(BEATS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [CNT_W-1:0]      idx_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   output logic [LINE_WIDTH-1:0] line_o
);

   logic [LINE_WIDTH-1:0] line_q;

   // Each slot has its own enable so only the addressed word toggles.
   for (genvar b = 0; b < BEATS; b++) begin : g_slot
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            line_q[b*WORD_WIDTH +: WORD_WIDTH] <= '0;
         end else if (we_i && (idx_i == CNT_W'(b))) begin
            line_q[b*WORD_WIDTH +: WORD_WIDTH] <= wdata_i;
         end
      end
   end

   assign line_o = line_q;

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side icache refill responder: fetches one line word-by-word from the instruction
// memory port (one beat outstanding at a time) and returns it with a single-cycle ack.
module icache_refill_responder
   import cache_defs::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = ICACHE_WORD_WIDTH,
   parameter int LINE_WIDTH = ICACHE_LINE_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  icache2mem_req_i,
   input  logic [ADDR_WIDTH-1:0] icache2mem_addr_i,
   output logic                  mem2icache_ack_o,
   output logic [LINE_WIDTH-1:0] mem2icache_data_o,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [WORD_WIDTH-1:0] imem_rdata_i
);

   localparam int BEATS   = LINE_WIDTH / WORD_WIDTH;
   localparam int CNT_W   = $clog2(BEATS);
   localparam int WORD_SH = $clog2(WORD_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

   type_icache_resp_states_e state_q;
   logic [CNT_W-1:0]         beat_cnt_q;
   logic [ADDR_WIDTH-1:0]    base_q;
   logic                     last_beat;
   logic                     buf_we;

   assign last_beat = (beat_cnt_q == LAST_BEAT);
   // A kill in WAIT discards that cycle's data unless it completes the line.
   assign buf_we    = (state_q == RESP_WAIT) && imem_rvalid_i && (icache2mem_req_i || last_beat);

   assign imem_req_o       = (state_q == RESP_ISSUE) && icache2mem_req_i;
   assign imem_addr_o      = base_q + (ADDR_WIDTH'(beat_cnt_q) << WORD_SH);
   assign mem2icache_ack_o = (state_q == RESP_ACK);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RESP_IDLE;
         beat_cnt_q <= '0;
         base_q     <= '0;
      end else begin
         case (state_q)
            RESP_IDLE: begin
               if (icache2mem_req_i) begin
                  base_q     <= icache2mem_addr_i & ~LINE_MASK;
                  beat_cnt_q <= '0;
                  state_q    <= RESP_ISSUE;
               end
            end
            RESP_ISSUE: begin
               if (!icache2mem_req_i) begin
                  state_q <= RESP_IDLE;
               end else if (imem_gnt_i) begin
                  state_q <= RESP_WAIT;
               end
            end
            RESP_WAIT: begin
               if (imem_rvalid_i && last_beat) begin
                  state_q <= RESP_ACK;
               end else if (!icache2mem_req_i) begin
                  // Data already returned this cycle means nothing is left to drain.
                  state_q <= imem_rvalid_i ? RESP_IDLE : RESP_DRAIN;
               end else if (imem_rvalid_i) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  state_q    <= RESP_ISSUE;
               end
            end
            RESP_ACK: begin
               state_q <= RESP_IDLE;
            end
            RESP_DRAIN: begin
               if (imem_rvalid_i) begin
                  state_q <= RESP_IDLE;
               end
            end
            default: begin
               state_q <= RESP_IDLE;
            end
         endcase
      end
   end

   icache_refill_buffer #(
      .WORD_WIDTH (WORD_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (buf_we),
      .idx_i   (beat_cnt_q),
      .wdata_i (imem_rdata_i),
      .line_o  (mem2icache_data_o)
   );

endmodule
